// File: rtl/controller_responder.sv
// controller_responder: device side of a latch/pulse serial game-controller link.
// Synchronizes host latch/pulse, snapshots buttons on latch and shifts them out MSB first, active-low.
module controller_responder #(
    parameter int   NUM_BUTTONS = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_VALUE  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   latch_in,
    input  logic                   pulse_in,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   data_out,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int CW = $clog2(NUM_BUTTONS + 1);
    typedef enum logic [1:0] {IDLE, LATCHED, SHIFTING, DONE} state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] lsync_q, psync_q;
    logic                   lhist_q, phist_q, lrise_q, lfall_q, prise_q;
    logic [NUM_BUTTONS-1:0] shift_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   data_q, busy_q, done_q, shift_d;
    assign cnt_d   = (cnt_q == CW'(NUM_BUTTONS)) ? cnt_q : cnt_q + 1'b1;
    // A pulse landing on the latch-fall cycle shifts immediately; a simultaneous latch rise wins.
    assign shift_d = prise_q && !lrise_q &&
                     (state_q == SHIFTING || (state_q == LATCHED && lfall_q));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lsync_q <= '0;
            psync_q <= '0;
            lhist_q <= 1'b0;
            phist_q <= 1'b0;
            lrise_q <= 1'b0;
            lfall_q <= 1'b0;
            prise_q <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            lsync_q <= {lsync_q[SYNC_STAGES-2:0], latch_in};
            psync_q <= {psync_q[SYNC_STAGES-2:0], pulse_in};
            lhist_q <= lsync_q[SYNC_STAGES-1];
            phist_q <= psync_q[SYNC_STAGES-1];
            lrise_q <= lsync_q[SYNC_STAGES-1] && !lhist_q;
            lfall_q <= !lsync_q[SYNC_STAGES-1] && lhist_q;
            prise_q <= psync_q[SYNC_STAGES-1] && !phist_q;
            done_q  <= 1'b0;
            if (lrise_q || (state_q == LATCHED && !lfall_q)) begin
                state_q <= LATCHED;
                shift_q <= buttons;
                data_q  <= ~buttons[NUM_BUTTONS-1];
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else if (state_q == LATCHED) begin
                state_q <= SHIFTING;
            end else if (state_q == IDLE) begin
                data_q <= 1'b1;
            end else if (state_q == DONE && prise_q) begin
                cnt_q  <= cnt_d;
                data_q <= FILL_VALUE;
            end
            if (shift_d) begin
                shift_q <= {shift_q[NUM_BUTTONS-2:0], 1'b0};
                cnt_q   <= cnt_d;
                data_q  <= ~shift_q[NUM_BUTTONS-2];
                if (cnt_d == CW'(NUM_BUTTONS - 1)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end
    assign data_out   = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule
